// File: rtl/md_ctrl.sv
// HI/LO sequencing for the multiply/divide unit: issues multdiv starts, HI/LO writes,
// models the fixed operation latency, stalls dependent instructions and flags misuse.
module md_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_md_en,
  input  logic [2:0] ex_op,
  input  logic       ex_flush,
  input  logic       id_md_use,
  output logic       start,
  output logic [2:0] mdctr,
  output logic       hiwrite,
  output logic       lowrite,
  output logic       busy,
  output logic       stall,
  output logic       done,
  output logic       err
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [3:0] MulCycles = 4'd5;
  localparam logic [3:0] DivCycles = 4'd10;

  localparam logic [2:0] OpMthi = 3'd4;
  localparam logic [2:0] OpMtlo = 3'd5;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       go;
  logic       violation;

  assign busy      = (state_q == StBusy);
  assign done      = done_q;
  assign err       = err_q;
  assign go        = ex_md_en & ~ex_flush & ~busy;
  // A live HI/LO instruction reaching EX while the unit is occupied means the stall failed.
  assign violation = ex_md_en & ~ex_flush & busy;

  // Combinational pipeline controls, forced low while reset is held.
  always_comb begin
    start   = 1'b0;
    hiwrite = 1'b0;
    lowrite = 1'b0;
    mdctr   = 3'd0;
    stall   = 1'b0;
    if (!rst) begin
      start   = go & ~ex_op[2];
      hiwrite = go & (ex_op == OpMthi);
      lowrite = go & (ex_op == OpMtlo);
      mdctr   = start ? {1'b0, ex_op[1:0]} : 3'd0;
      stall   = id_md_use & (busy | start);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = err_q | violation;
    unique case (state_q)
      StIdle: begin
        cnt_d = 4'd0;
        if (start) begin
          state_d = StBusy;
          cnt_d   = ex_op[1] ? DivCycles : MulCycles;
        end
      end
      StBusy: begin
        // Treating 0 like 1 keeps the counter from ever wrapping.
        if (cnt_q <= 4'd1) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: one task per scenario, cycle-numbered expectations.
module tb_md_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_md_en;
  logic [2:0] ex_op;
  logic       ex_flush;
  logic       id_md_use;
  logic       start;
  logic [2:0] mdctr;
  logic       hiwrite;
  logic       lowrite;
  logic       busy;
  logic       stall;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;

  md_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .ex_md_en (ex_md_en),
    .ex_op    (ex_op),
    .ex_flush (ex_flush),
    .id_md_use(id_md_use),
    .start    (start),
    .mdctr    (mdctr),
    .hiwrite  (hiwrite),
    .lowrite  (lowrite),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    ex_md_en  = 1'b0;
    ex_op     = 3'd0;
    ex_flush  = 1'b0;
    id_md_use = 1'b0;
  endtask

  // Each cycle begins 1ns after the rising edge; checks happen 1ns later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ex_md_en = 1'b1; ex_op = 3'd0; ex_flush = 1'b0; id_md_use = 1'b1;
    #2;
    checks++;
    if ({start, stall, mdctr} !== 5'b0) begin
      errors++; $display("FAIL reset_comb: start/stall/mdctr=%b required 00000", {start, stall, mdctr});
    end
    ex_op = 3'd4;
    #1;
    checks++;
    if (hiwrite !== 1'b0) begin
      errors++; $display("FAIL reset_hiwrite: got %b required 0", hiwrite);
    end
    next_cycle();
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++; $display("FAIL reset_state: busy/done/err=%b required 000", {busy, done, err});
    end
    idle_inputs();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_decode();
    for (int op = 0; op < 8; op++) begin
      ex_md_en = 1'b1; ex_op = op[2:0];
      #1;
      checks++;
      if ({start, mdctr, hiwrite, lowrite} !== {(op < 4), (op < 4) ? op[2:0] : 3'd0, (op == 4), (op == 5)}) begin
        errors++;
        $display("FAIL decode_op%0d: start/mdctr/hi/lo=%b required %b", op,
                 {start, mdctr, hiwrite, lowrite},
                 {(op < 4), (op < 4) ? op[2:0] : 3'd0, (op == 4), (op == 5)});
      end
      ex_md_en = 1'b0;
      next_cycle();
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL decode_nobusy: busy=%b required 0", busy);
    end
  endtask

  task automatic test_mult();
    ex_md_en = 1'b1; ex_op = 3'd0;
    #1;
    checks++;
    if ({start, mdctr, busy} !== {1'b1, 3'd0, 1'b0}) begin
      errors++; $display("FAIL mult_c0: start/mdctr/busy=%b required 10000", {start, mdctr, busy});
    end
    next_cycle();
    idle_inputs();
    for (int c = 1; c <= 7; c++) begin
      #1;
      checks++;
      if ({busy, done} !== {(c <= 5), (c == 6)}) begin
        errors++;
        $display("FAIL mult_c%0d: busy/done=%b required %b", c, {busy, done}, {(c <= 5), (c == 6)});
      end
      next_cycle();
    end
  endtask

  task automatic test_divu_stall();
    ex_md_en = 1'b1; ex_op = 3'd3; id_md_use = 1'b1;
    #1;
    checks++;
    if ({stall, mdctr} !== {1'b1, 3'd3}) begin
      errors++; $display("FAIL divu_c0: stall/mdctr=%b required 1011", {stall, mdctr});
    end
    next_cycle();
    ex_md_en = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      #1;
      checks++;
      if ({stall, busy, done} !== {(c <= 10), (c <= 10), (c == 11)}) begin
        errors++;
        $display("FAIL divu_c%0d: stall/busy/done=%b required %b", c, {stall, busy, done},
                 {(c <= 10), (c <= 10), (c == 11)});
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_mthi_mfhi();
    ex_md_en = 1'b1; ex_op = 3'd4;
    #1;
    checks++;
    if ({hiwrite, lowrite, start} !== 3'b100) begin
      errors++; $display("FAIL mthi: hi/lo/start=%b required 100", {hiwrite, lowrite, start});
    end
    next_cycle();
    ex_md_en = 1'b0;
    #1;
    checks++;
    if ({busy, hiwrite} !== 2'b00) begin
      errors++; $display("FAIL mthi_after: busy/hiwrite=%b required 00", {busy, hiwrite});
    end
    ex_md_en = 1'b1; ex_op = 3'd6; id_md_use = 1'b1;
    #1;
    checks++;
    if ({start, mdctr, hiwrite, lowrite, stall} !== 7'b0) begin
      errors++;
      $display("FAIL mfhi: start/mdctr/hi/lo/stall=%b required 0000000",
               {start, mdctr, hiwrite, lowrite, stall});
    end
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL mfhi_after: busy=%b required 0", busy);
    end
    next_cycle();
  endtask

  task automatic test_flush();
    ex_md_en = 1'b1; ex_op = 3'd2; ex_flush = 1'b1;
    #1;
    checks++;
    if (start !== 1'b0) begin
      errors++; $display("FAIL flush_start: start=%b required 0", start);
    end
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_nobusy: busy=%b required 0", busy);
    end
    ex_md_en = 1'b1; ex_op = 3'd0;
    next_cycle();
    idle_inputs();
    for (int c = 1; c <= 7; c++) begin
      if (c == 3) begin
        ex_md_en = 1'b1; ex_flush = 1'b1; ex_op = 3'd2;
      end else begin
        idle_inputs();
      end
      #1;
      checks++;
      if ({busy, done, err} !== {(c <= 5), (c == 6), 1'b0}) begin
        errors++;
        $display("FAIL flush_mult_c%0d: busy/done/err=%b required %b", c, {busy, done, err},
                 {(c <= 5), (c == 6), 1'b0});
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_violation();
    ex_md_en = 1'b1; ex_op = 3'd2;
    next_cycle();
    idle_inputs();
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin
        ex_md_en = 1'b1; ex_op = 3'd1;
      end else if (c == 4) begin
        ex_md_en = 1'b1; ex_op = 3'd4;
      end else begin
        idle_inputs();
      end
      #1;
      checks++;
      if ({start, hiwrite, busy, done, err} !== {2'b00, (c <= 10), (c == 11), (c >= 3)}) begin
        errors++;
        $display("FAIL viol_c%0d: start/hi/busy/done/err=%b required %b", c,
                 {start, hiwrite, busy, done, err}, {2'b00, (c <= 10), (c == 11), (c >= 3)});
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    ex_md_en = 1'b1; ex_op = 3'd2;
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
    next_cycle();
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, err, done, start} !== 4'b0000) begin
      errors++; $display("FAIL rst_mid: busy/err/done/start=%b required 0000", {busy, err, done, start});
    end
    next_cycle();
    rst = 1'b0;
    next_cycle();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL rst_release: busy/done=%b required 00", {busy, done});
    end
    ex_md_en = 1'b1; ex_op = 3'd1;
    next_cycle();
    idle_inputs();
    for (int c = 1; c <= 7; c++) begin
      #1;
      checks++;
      if ({busy, done} !== {(c <= 5), (c == 6)}) begin
        errors++;
        $display("FAIL rst_mult_c%0d: busy/done=%b required %b", c, {busy, done}, {(c <= 5), (c == 6)});
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    ex_md_en = 1'b1; ex_op = 3'd0;
    next_cycle();
    idle_inputs();
    for (int c = 1; c <= 18; c++) begin
      if (c == 6) begin
        ex_md_en = 1'b1; ex_op = 3'd3;
      end else begin
        idle_inputs();
      end
      #1;
      checks++;
      if ({busy, done, start} !== {(c <= 5) || (c >= 7 && c <= 16), (c == 6) || (c == 17), (c == 6)}) begin
        errors++;
        $display("FAIL b2b_c%0d: busy/done/start=%b required %b", c, {busy, done, start},
                 {(c <= 5) || (c >= 7 && c <= 16), (c == 6) || (c == 17), (c == 6)});
      end
      if (c == 6) begin
        checks++;
        if (mdctr !== 3'd3) begin
          errors++; $display("FAIL b2b_mdctr: mdctr=%0d required 3", mdctr);
        end
      end
      next_cycle();
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL b2b_err: err=%b required 0", err);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    #1;
    test_reset();
    test_decode();
    test_mult();
    test_divu_stall();
    test_mthi_mfhi();
    test_flush();
    test_violation();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 The block SHALL expose the following ports:
- clk  in  1  sole clock; rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- ex_md_en  in  1  EX stage holds a valid HI/LO instruction this cycle.
- ex_op  in  3  HI/LO op: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo.
- ex_flush  in  1  EX instruction is killed (exception/interrupt) this cycle.
- id_md_use  in  1  ID stage instruction reads or writes HI/LO (any of ops 0-7).
- start  out  1  start pulse to multdiv.
- mdctr  out  3  operation select to multdiv: 0 mult, 1 multu, 2 div, 3 divu.
- hiwrite  out  1  write HI from A (mthi).
- lowrite  out  1  write LO from A (mtlo).
- busy  out  1  multdiv operation in progress (block's own model).
- stall  out  1  freeze PC/IF/ID, insert bubble into EX.
- done  out  1  one-cycle pulse, result available.
- err  out  1  sticky protocol-violation flag.

Function
REQ-002 States SHALL be IDLE and BUSY; busy SHALL equal (state==BUSY).
REQ-003 Issue condition `go` SHALL be ex_md_en & ~ex_flush & ~busy.
REQ-004 start SHALL be combinational: go & (ex_op<=3).
REQ-005 mdctr SHALL be combinational: ex_op[1:0] when start is 1, else 0.
REQ-006 hiwrite SHALL be go & (ex_op==4); lowrite SHALL be go & (ex_op==5); neither SHALL cause BUSY.
REQ-007 ops 6/7 (mfhi/mflo) SHALL produce no multdiv control output.
REQ-008 On a clock edge with start=1, state SHALL go IDLE->BUSY and the 4-bit counter cnt SHALL load 5 (ops 0,1) or 10 (ops 2,3).
REQ-009 In BUSY, cnt SHALL decrement by 1 per edge; on the edge where cnt==1, state SHALL return to IDLE and cnt SHALL become 0.
REQ-010 Latency: start in cycle k SHALL give busy=1 in cycles k+1..k+N (N=5 or 10) and busy=0 in cycle k+N+1.
REQ-011 done SHALL be a registered pulse, high only in cycle k+N+1.
REQ-012 Divide by zero SHALL take the full 10 cycles with no special handling.
REQ-013 stall SHALL be combinational: id_md_use & (busy | start).
REQ-014 ex_flush SHALL suppress start/hiwrite/lowrite only in the same cycle; a flush while BUSY SHALL NOT abort the operation (cnt continues).
REQ-015 ex_md_en=1 with busy=1 and ex_flush=0 is a pipeline violation: outputs SHALL be unaffected (no restart, no HI/LO write), and err SHALL set on that edge and hold until reset.
REQ-016 Back-to-back operations: a new start SHALL be accepted in cycle k+N+1, the same cycle done is high.
REQ-017 cnt SHALL never wrap; in IDLE, cnt SHALL hold 0.

Reset
REQ-018 While rst=1, regardless of clk: state=IDLE, cnt=0, busy=0, done=0, err=0.
REQ-019 While rst=1, start, hiwrite, lowrite, mdctr and stall SHALL all be 0 (combinational outputs gated by rst).
REQ-020 Reset asserted mid-operation SHALL abandon it immediately; the first cycle after release SHALL be IDLE with no done pulse.

Verification
REQ-021 mult: ex_md_en=1, ex_op=0 in cycle 0 -> start=1, mdctr=0 in cycle 0; busy=1 in cycles 1-5; done=1 in cycle 6.
REQ-022 divu: ex_op=3 in cycle 0 with id_md_use=1 held -> stall=1 in cycles 0-10; stall=0 and done=1 in cycle 11.
REQ-023 mthi: ex_op=4 -> hiwrite=1 for one cycle, start=0, busy stays 0; ex_op=6 -> all control outputs 0.
REQ-024 Flush: ex_op=2 with ex_flush=1 -> start=0, busy stays 0; ex_flush=1 in cycle 3 of a mult -> busy still falls after cycle 5.
REQ-025 Violation: ex_md_en=1, ex_op=1 in cycle 2 of a div -> no start, div completes at cycle 10, err=1 from cycle 3 onward until rst.
REQ-026 Reset: rst pulsed in cycle 4 of a div -> busy=0, err=0 immediately; next mult after release yields exactly 5 busy cycles.
